// File: rtl/cbs_row_feeder_if.sv
// -----------------------------------------------------------------------------
// cbs_row_feeder_if
// Purpose : bundles the pixel-input and window-output handshakes of the CBS
//           row feeder so producer, feeder and conv array share one port.
// Signals : pix_in/pix_valid/pix_sof/pix_ready  raster pixel stream (valid/ready)
//           img_R1/img_R2/img_R3                3 x 10-pixel window, MSB byte = win_col
//           win_valid/win_ready                 window handshake toward the conv array
//           win_col/win_row                     window start column / row of img_R3
//           frame_done                          1-cycle end-of-frame pulse
// Modports: master = feeder side (drives pix_ready and all window outputs)
//           slave  = environment side (pixel source + conv consumer)
// Parameters must match those of the cbs_row_feeder instance it is bound to.
// -----------------------------------------------------------------------------
interface cbs_row_feeder_if #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [7:0]    pix_in;
    logic          pix_valid;
    logic          pix_sof;
    logic          pix_ready;
    logic [79:0]   img_R1;
    logic [79:0]   img_R2;
    logic [79:0]   img_R3;
    logic          win_valid;
    logic          win_ready;
    logic [CW-1:0] win_col;
    logic [RW-1:0] win_row;
    logic          frame_done;

    modport master (
        input  pix_in, pix_valid, pix_sof, win_ready,
        output pix_ready, img_R1, img_R2, img_R3, win_valid, win_col, win_row, frame_done
    );

    modport slave (
        output pix_in, pix_valid, pix_sof, win_ready,
        input  pix_ready, img_R1, img_R2, img_R3, win_valid, win_col, win_row, frame_done
    );
endinterface

// File: rtl/cbs_row_feeder.sv
// -----------------------------------------------------------------------------
// cbs_row_feeder
// Purpose : turns a raster 8-bit pixel stream into 3-row x 10-pixel windows for
//           the 8-wide 3x3 conv stage. Two previous rows are kept in line
//           buffers; the current row is written into the oldest buffer.
// Ports   : clk    rising-edge clock
//           rst_n  asynchronous active-low reset
//           io_bus cbs_row_feeder_if.master (pixel in, window out, frame_done)
// Params  : IMG_W pixels per row (multiple of 8, >= 16)
//           IMG_H rows per frame (>= 3)
// Option  : CBS_FEEDER_TOP_PAD_EN - when defined, windows are also produced for
//           rows 0 and 1 with the rows above the frame reading as 0x00.
// -----------------------------------------------------------------------------
module cbs_row_feeder #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    cbs_row_feeder_if.master   io_bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Line buffers: three row stores used in rotation.
    logic [7:0]    r_lb [3][IMG_W];

    // Position of the next expected pixel and the buffer it goes to.
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [1:0]    r_buf;

    state_t        r_state;
    state_t        w_state_next;
    logic          w_stream_en;

    // Output window register.
    logic          r_win_valid;
    logic [79:0]   r_img1;
    logic [79:0]   r_img2;
    logic [79:0]   r_img3;
    logic [CW-1:0] r_win_col;
    logic [RW-1:0] r_win_row;
    logic          r_frame_done;

    logic          w_pix_ready;
    logic          w_accept;
    logic          w_handshake;
    logic [CW-1:0] w_pix_col;
    logic [RW-1:0] w_pix_row;
    logic [1:0]    w_buf;
    logic [1:0]    w_buf_p1;
    logic [1:0]    w_buf_p2;
    logic          w_col_last;
    logic          w_row_last;
    logic          w_trig_mid;
    logic          w_trigger;
    logic [CW-1:0] w_start;
    logic          w_r1_zero;
    logic          w_r2_zero;
    logic [79:0]   w_img1;
    logic [79:0]   w_img2;
    logic [79:0]   w_img3;

    // A full output register only frees up when the conv stage takes it.
    assign w_pix_ready = !r_win_valid || io_bus.win_ready;
    assign w_accept    = io_bus.pix_valid && w_pix_ready;
    assign w_handshake = r_win_valid && io_bus.win_ready;

    // sof overrides the tracked position, so the pixel lands at (0,0).
    assign w_pix_col = io_bus.pix_sof ? '0 : r_col;
    assign w_pix_row = io_bus.pix_sof ? '0 : r_row;
    assign w_buf     = io_bus.pix_sof ? 2'd0 : r_buf;
    assign w_buf_p1  = (w_buf    == 2'd0) ? 2'd2 : w_buf    - 2'd1;
    assign w_buf_p2  = (w_buf_p1 == 2'd0) ? 2'd2 : w_buf_p1 - 2'd1;

    assign w_col_last = (w_pix_col == CW'(IMG_W - 1));
    assign w_row_last = (w_pix_row == RW'(IMG_H - 1));

    // Columns 9, 17, ... complete the window starting 9 columns earlier.
    assign w_trig_mid = (w_pix_col[2:0] == 3'd1) && (w_pix_col != CW'(1));
    assign w_trigger  = w_accept && w_stream_en && (w_trig_mid || w_col_last);
    assign w_start    = w_col_last ? CW'(IMG_W - 8) : (w_pix_col - CW'(9));

`ifdef CBS_FEEDER_TOP_PAD_EN
    assign w_r1_zero = (w_pix_row < RW'(2));
    assign w_r2_zero = (w_pix_row == '0);
`else
    assign w_r1_zero = 1'b0;
    assign w_r2_zero = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            if (io_bus.pix_sof) begin
                w_state_next = FILL;
            end else if (w_col_last && w_row_last) begin
                w_state_next = FILL;
            end else if (w_pix_row == RW'(2) && w_pix_col == '0) begin
                w_state_next = STREAM;
            end
        end
    end

    always_comb begin
`ifdef CBS_FEEDER_TOP_PAD_EN
        w_stream_en = 1'b1;
`else
        w_stream_en = (r_state == STREAM);
`endif
    end

    // ------------------------------------------------------------------
    // Position counters and buffer rotation
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
            r_buf <= 2'd0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : w_pix_row + RW'(1);
                r_buf <= (w_buf == 2'd2) ? 2'd0 : w_buf + 2'd1;
            end else begin
                r_col <= w_pix_col + CW'(1);
                r_row <= w_pix_row;
                r_buf <= w_buf;
            end
        end
    end

    // Line-buffer storage has no reset; stale contents are never exposed.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb[w_buf][w_pix_col] <= io_bus.pix_in;
        end
    end

    // ------------------------------------------------------------------
    // Window assembly: byte gi holds column w_start+gi. The current row's
    // trigger pixel is not in the buffer yet, so it is bypassed from pix_in.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 10; gi++) begin : g_byte
        logic [CW:0]   w_abs;
        logic [CW-1:0] w_idx;
        logic          w_in_img;
        logic          w_is_pix;

        assign w_abs    = {1'b0, w_start} + (CW+1)'(gi);
        assign w_idx    = w_abs[CW-1:0];
        assign w_in_img = (w_abs < (CW+1)'(IMG_W));
        assign w_is_pix = (w_abs == {1'b0, w_pix_col});

        assign w_img3[79-8*gi -: 8] = !w_in_img ? 8'h00 :
                                      w_is_pix  ? io_bus.pix_in :
                                                  r_lb[w_buf][w_idx];
        assign w_img2[79-8*gi -: 8] = (!w_in_img || w_r2_zero) ? 8'h00 : r_lb[w_buf_p1][w_idx];
        assign w_img1[79-8*gi -: 8] = (!w_in_img || w_r1_zero) ? 8'h00 : r_lb[w_buf_p2][w_idx];
    end

    // ------------------------------------------------------------------
    // Output register. A trigger accepted in the handshake cycle reloads
    // the register directly, giving back-to-back windows.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_valid  <= 1'b0;
            r_img1       <= '0;
            r_img2       <= '0;
            r_img3       <= '0;
            r_win_col    <= '0;
            r_win_row    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_trigger) begin
                r_win_valid <= 1'b1;
                r_img1      <= w_img1;
                r_img2      <= w_img2;
                r_img3      <= w_img3;
                r_win_col   <= w_start;
                r_win_row   <= w_pix_row;
            end else if (w_handshake) begin
                r_win_valid <= 1'b0;
            end
            r_frame_done <= w_handshake &&
                            (r_win_row == RW'(IMG_H - 1)) &&
                            (r_win_col == CW'(IMG_W - 8));
        end
    end

    assign io_bus.pix_ready  = w_pix_ready;
    assign io_bus.win_valid  = r_win_valid;
    assign io_bus.img_R1     = r_img1;
    assign io_bus.img_R2     = r_img2;
    assign io_bus.img_R3     = r_img3;
    assign io_bus.win_col    = r_win_col;
    assign io_bus.win_row    = r_win_row;
    assign io_bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_cbs_row_feeder.sv
module tb_cbs_row_feeder;
    localparam int W = 16;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cbs_row_feeder_if #(.IMG_W(W), .IMG_H(H)) bus ();

    cbs_row_feeder #(.IMG_W(W), .IMG_H(H)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int n_win  = 0;
    int n_fd   = 0;

    // Window monitor: one line per consumed window.
    always @(negedge clk) begin
        if (rst_n && bus.win_valid && bus.win_ready) begin
            n_win++;
            $display("window row=%0d col=%0d R1=%h R2=%h R3=%h",
                     bus.win_row, bus.win_col, bus.img_R1, bus.img_R2, bus.img_R3);
        end
        if (rst_n && bus.frame_done) n_fd++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] pv(input int r, input int c);
        logic [31:0] rr;
        logic [31:0] cc;
        rr = r;
        cc = c;
        return {rr[3:0], cc[3:0]};
    endfunction

    // Expected window of row r starting at column s; columns past the row are 0.
    function automatic logic [79:0] exp_win(input int r, input int s);
        logic [79:0] v;
        v = '0;
        for (int k = 0; k < 10; k++)
            if (s + k < W) v[79-8*k -: 8] = pv(r, s + k);
        return v;
    endfunction

    // Present one pixel and return 1ns after the edge that accepts it.
    task automatic send_pix(input int r, input int c, input bit sof);
        bit done;
        done = 1'b0;
        bus.pix_in    = pv(r, c);
        bus.pix_sof   = sof;
        bus.pix_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.pix_ready === 1'b1) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout pixel (%0d,%0d) not accepted within 50 cycles", r, c);
        end
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
    endtask

    task automatic send_rows(input int r0, input int c0, input int r1, input int c1);
        for (int idx = r0 * W + c0; idx <= r1 * W + c1; idx++)
            send_pix(idx / W, idx % W, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.pix_in    = '0;
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.win_ready = 1'b1;
        #12;
        checks++;
        if (bus.pix_ready !== 1'b1) begin errors++; $display("FAIL reset_pix_ready got=%b exp=1", bus.pix_ready); end
        checks++;
        if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
            errors++; $display("FAIL reset_valid got win_valid=%b frame_done=%b exp=0/0", bus.win_valid, bus.frame_done);
        end
        checks++;
        if (bus.img_R1 !== '0 || bus.img_R3 !== '0 || bus.win_col !== '0 || bus.win_row !== '0) begin
            errors++; $display("FAIL reset_outputs got R1=%h R3=%h col=%0d row=%0d exp=all 0",
                               bus.img_R1, bus.img_R3, bus.win_col, bus.win_row);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_first_window();
        int n0;
        int f0;
        n0 = n_win;
        f0 = n_fd;
        bus.win_ready = 1'b1;
        send_pix(0, 0, 1'b1);
        send_rows(0, 1, 2, 8);
        checks++;
        if (bus.win_valid !== 1'b0 || n_win != n0) begin
            errors++; $display("FAIL fill_no_window got win_valid=%b windows=%0d exp=0/0", bus.win_valid, n_win - n0);
        end
        send_pix(2, 9, 1'b0);
        checks++;
        if (bus.win_valid !== 1'b1 || bus.win_col !== 4'd0 || bus.win_row !== 2'd2) begin
            errors++; $display("FAIL first_win_ctl got valid=%b col=%0d row=%0d exp=1/0/2", bus.win_valid, bus.win_col, bus.win_row);
        end
        checks++;
        if (bus.img_R1 !== 80'h00010203040506070809 || bus.img_R2 !== 80'h10111213141516171819 ||
            bus.img_R3 !== 80'h20212223242526272829) begin
            errors++; $display("FAIL first_win_data got R1=%h R2=%h R3=%h exp=00..09/10..19/20..29",
                               bus.img_R1, bus.img_R2, bus.img_R3);
        end
        send_rows(2, 10, 2, 14);
        send_pix(2, 15, 1'b0);
        checks++;
        if (bus.win_valid !== 1'b1 || bus.win_col !== 4'd8 ||
            bus.img_R1 !== 80'h08090A0B0C0D0E0F0000 || bus.img_R2 !== 80'h18191A1B1C1D1E1F0000 ||
            bus.img_R3 !== 80'h28292A2B2C2D2E2F0000) begin
            errors++; $display("FAIL last_win got valid=%b col=%0d R1=%h R2=%h R3=%h exp=1/8/08..0F0000/18..1F0000/28..2F0000",
                               bus.win_valid, bus.win_col, bus.img_R1, bus.img_R2, bus.img_R3);
        end
        send_rows(3, 0, 3, 14);
        send_pix(3, 15, 1'b0);
        checks++;
        if (bus.win_row !== 2'd3 || bus.win_col !== 4'd8 || bus.img_R3 !== exp_win(3, 8) ||
            bus.img_R1 !== exp_win(1, 8) || bus.frame_done !== 1'b0) begin
            errors++; $display("FAIL row3_last_win got row=%0d col=%0d R1=%h R3=%h fd=%b exp=3/8/%h/%h/0",
                               bus.win_row, bus.win_col, bus.img_R1, bus.img_R3, bus.frame_done, exp_win(1, 8), exp_win(3, 8));
        end
        idle(1);
        checks++;
        if (bus.frame_done !== 1'b1) begin errors++; $display("FAIL frame_done_pulse got=%b exp=1", bus.frame_done); end
        idle(1);
        checks++;
        if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_width got=%b exp=0", bus.frame_done); end
        checks++;
        if (n_win - n0 != 4 || n_fd - f0 != 1) begin
            errors++; $display("FAIL frame_counts got windows=%0d frame_done=%0d exp=4/1", n_win - n0, n_fd - f0);
        end
    endtask

    task automatic test_stall();
        int n0;
        int f0;
        n0 = n_win;
        f0 = n_fd;
        bus.win_ready = 1'b0;
        send_pix(0, 0, 1'b1);
        send_rows(0, 1, 2, 9);
        bus.pix_in    = pv(2, 10);
        bus.pix_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.pix_ready !== 1'b0 || bus.win_valid !== 1'b1 || bus.win_col !== 4'd0 ||
                bus.img_R1 !== exp_win(0, 0) || bus.img_R2 !== exp_win(1, 0) || bus.img_R3 !== exp_win(2, 0)) begin
                errors++; $display("FAIL stall_hold cycle %0d got ready=%b valid=%b col=%0d R1=%h R3=%h exp=0/1/0/%h/%h",
                                   i, bus.pix_ready, bus.win_valid, bus.win_col, bus.img_R1, bus.img_R3,
                                   exp_win(0, 0), exp_win(2, 0));
            end
        end
        idle(1);
        bus.win_ready = 1'b1;
        send_pix(2, 10, 1'b0);
        send_rows(2, 11, 2, 15);
        checks++;
        if (bus.win_col !== 4'd8 || bus.img_R1 !== exp_win(0, 8) || bus.img_R2 !== exp_win(1, 8) ||
            bus.img_R3 !== exp_win(2, 8)) begin
            errors++; $display("FAIL stall_release got col=%0d R1=%h R2=%h R3=%h exp=8/%h/%h/%h",
                               bus.win_col, bus.img_R1, bus.img_R2, bus.img_R3, exp_win(0, 8), exp_win(1, 8), exp_win(2, 8));
        end
        send_rows(3, 0, 3, 15);
        idle(3);
        checks++;
        if (n_win - n0 != 4 || n_fd - f0 != 1) begin
            errors++; $display("FAIL stall_counts got windows=%0d frame_done=%0d exp=4/1", n_win - n0, n_fd - f0);
        end
    endtask

    task automatic test_sof_restart();
        int n_mid;
        int f0;
        bus.win_ready = 1'b1;
        send_pix(0, 0, 1'b1);
        send_rows(0, 1, 3, 4);
        idle(2);
        n_mid = n_win;
        f0    = n_fd;
        send_pix(0, 0, 1'b1);
        send_rows(0, 1, 2, 8);
        idle(1);
        checks++;
        if (n_win != n_mid || bus.win_valid !== 1'b0 || n_fd != f0) begin
            errors++; $display("FAIL sof_no_window got windows=%0d valid=%b fd=%0d exp=0/0/0", n_win - n_mid, bus.win_valid, n_fd - f0);
        end
        send_pix(2, 9, 1'b0);
        checks++;
        if (bus.win_valid !== 1'b1 || bus.win_row !== 2'd2 || bus.win_col !== 4'd0 ||
            bus.img_R1 !== exp_win(0, 0) || bus.img_R2 !== exp_win(1, 0) || bus.img_R3 !== exp_win(2, 0)) begin
            errors++; $display("FAIL sof_first_win got valid=%b row=%0d col=%0d R1=%h R2=%h R3=%h exp=1/2/0/%h/%h/%h",
                               bus.win_valid, bus.win_row, bus.win_col, bus.img_R1, bus.img_R2, bus.img_R3,
                               exp_win(0, 0), exp_win(1, 0), exp_win(2, 0));
        end
        send_rows(2, 10, 3, 15);
        idle(3);
    endtask

    task automatic test_reset_mid();
        bus.win_ready = 1'b0;
        send_pix(0, 0, 1'b1);
        send_rows(0, 1, 2, 9);
        checks++;
        if (bus.win_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got=%b exp=1", bus.win_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.win_valid !== 1'b0 || bus.pix_ready !== 1'b1 || bus.img_R3 !== '0 ||
            bus.win_col !== '0 || bus.win_row !== '0) begin
            errors++; $display("FAIL rst_async got valid=%b ready=%b R3=%h col=%0d row=%0d exp=0/1/0/0/0",
                               bus.win_valid, bus.pix_ready, bus.img_R3, bus.win_col, bus.win_row);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.win_ready = 1'b1;
        idle(1);
        // No sof: counters must have been returned to (0,0) by reset.
        send_rows(0, 0, 2, 8);
        checks++;
        if (bus.win_valid !== 1'b0) begin errors++; $display("FAIL rst_fill got valid=%b exp=0", bus.win_valid); end
        send_pix(2, 9, 1'b0);
        checks++;
        if (bus.win_valid !== 1'b1 || bus.win_row !== 2'd2 || bus.win_col !== 4'd0 ||
            bus.img_R1 !== 80'h00010203040506070809 || bus.img_R2 !== 80'h10111213141516171819 ||
            bus.img_R3 !== 80'h20212223242526272829) begin
            errors++; $display("FAIL rst_first_win got valid=%b row=%0d col=%0d R1=%h R2=%h R3=%h",
                               bus.win_valid, bus.win_row, bus.win_col, bus.img_R1, bus.img_R2, bus.img_R3);
        end
        send_rows(2, 10, 3, 15);
        idle(3);
    endtask

    initial begin
        test_reset();
        test_first_window();
        test_stall();
        test_sof_restart();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
